// File: rtl/iob_cache_axi_write_responder_pkg.sv
// Shared cache AXI encodings: burst types, response codes and write-responder FSM states.
package iob_cache_axi_write_responder_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_MEM  = 2'b10,
    ST_RESP = 2'b11
  } wr_state_e;

  // WRAP and the reserved encoding are both unsupported; oversize beats can't map onto the bus
  function automatic logic aw_err(input logic [1:0] burst, input logic [2:0] size,
                                  input logic [2:0] size_max);
    return (burst == BURST_WRAP) || (burst == BURST_RSVD) || (size > size_max);
  endfunction

endpackage

// File: rtl/iob_cache_axi_write_responder_if.sv
// AXI write channels plus the downstream memory write port of the cache write responder.
interface iob_cache_axi_write_responder_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8
);
  logic [AXI_ID_W-1:0]     axi_awid_i;
  logic [AXI_ADDR_W-1:0]   axi_awaddr_i;
  logic [AXI_LEN_W-1:0]    axi_awlen_i;
  logic [2:0]              axi_awsize_i;
  logic [1:0]              axi_awburst_i;
  logic                    axi_awvalid_i;
  logic                    axi_awready_o;

  logic [AXI_DATA_W-1:0]   axi_wdata_i;
  logic [AXI_DATA_W/8-1:0] axi_wstrb_i;
  logic                    axi_wlast_i;
  logic                    axi_wvalid_i;
  logic                    axi_wready_o;

  logic [AXI_ID_W-1:0]     axi_bid_o;
  logic [1:0]              axi_bresp_o;
  logic                    axi_bvalid_o;
  logic                    axi_bready_i;

  logic                    mem_valid_o;
  logic [AXI_ADDR_W-1:0]   mem_addr_o;
  logic [AXI_DATA_W-1:0]   mem_wdata_o;
  logic [AXI_DATA_W/8-1:0] mem_wstrb_o;
  logic                    mem_ready_i;

  modport slave (
    input  axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i, axi_awvalid_i,
    output axi_awready_o,
    input  axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
    output axi_wready_o,
    output axi_bid_o, axi_bresp_o, axi_bvalid_o,
    input  axi_bready_i,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ready_i
  );

  modport master (
    output axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i, axi_awvalid_i,
    input  axi_awready_o,
    output axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
    input  axi_wready_o,
    input  axi_bid_o, axi_bresp_o, axi_bvalid_o,
    output axi_bready_i,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_ready_i
  );
endinterface

// File: rtl/iob_cache_axi_burst_addr.sv
// Next-beat byte address: INCR steps by 2^size, FIXED holds; wraps modulo 2^AXI_ADDR_W.
module iob_cache_axi_burst_addr
  import iob_cache_axi_write_responder_pkg::*;
#(
  parameter int AXI_ADDR_W = 32
) (
  input  logic [AXI_ADDR_W-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [AXI_ADDR_W-1:0] next_addr_o
);
  logic [AXI_ADDR_W-1:0] step;

  always_comb begin
    step        = {{(AXI_ADDR_W-1){1'b0}}, 1'b1} << size_i;
    next_addr_o = (burst_i == BURST_FIXED) ? addr_i : addr_i + step;
  end
endmodule

// File: rtl/iob_cache_axi_write_responder.sv
// AXI write slave forwarding each accepted beat as a single memory write; one burst in flight.
module iob_cache_axi_write_responder
  import iob_cache_axi_write_responder_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  iob_cache_axi_write_responder_if.slave bus
);
  localparam int         STRB_W   = AXI_DATA_W / 8;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));

  wr_state_e               state_q, state_d;
  logic [AXI_ID_W-1:0]     id_q;
  logic [AXI_ADDR_W-1:0]   addr_q, next_addr;
  logic [AXI_LEN_W-1:0]    len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q, last_q;
  logic [AXI_LEN_W:0]      cnt_q, len_ext;
  logic                    awready_q, wready_q, mem_valid_q, bvalid_q;
  logic [AXI_ADDR_W-1:0]   mem_addr_q;
  logic [AXI_DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]       mem_wstrb_q;
  logic                    aw_hs, w_hs, m_hs, b_hs, wr_en, beat_err;

  iob_cache_axi_burst_addr #(.AXI_ADDR_W(AXI_ADDR_W)) u_burst_addr (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  always_comb begin
    len_ext  = {1'b0, len_q};
    aw_hs    = awready_q & bus.axi_awvalid_i;
    w_hs     = wready_q & bus.axi_wvalid_i;
    m_hs     = mem_valid_q & bus.mem_ready_i;
    b_hs     = bvalid_q & bus.axi_bready_i;
    // error raised by the current beat doesn't suppress that beat, only later ones
    wr_en    = !err_q && (cnt_q <= len_ext);
    beat_err = bus.axi_wlast_i ? (cnt_q != len_ext) : (cnt_q == len_ext);
    state_d  = state_q;
    case (state_q)
      ST_IDLE: if (aw_hs) state_d = ST_DATA;
      ST_DATA: if (w_hs) begin
        if (wr_en)                 state_d = ST_MEM;
        else if (bus.axi_wlast_i)  state_d = ST_RESP;
      end
      ST_MEM:  if (m_hs) state_d = last_q ? ST_RESP : ST_DATA;
      ST_RESP: if (b_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // handshake outputs are flops of the next state, so awready stays low until the first edge out of reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      bvalid_q    <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= (state_d == ST_IDLE);
      wready_q    <= (state_d == ST_DATA);
      mem_valid_q <= (state_d == ST_MEM);
      bvalid_q    <= (state_d == ST_RESP);
      case (state_q)
        ST_IDLE: if (aw_hs) begin
          id_q    <= bus.axi_awid_i;
          addr_q  <= bus.axi_awaddr_i;
          len_q   <= bus.axi_awlen_i;
          size_q  <= bus.axi_awsize_i;
          burst_q <= bus.axi_awburst_i;
          err_q   <= aw_err(bus.axi_awburst_i, bus.axi_awsize_i, SIZE_MAX);
          cnt_q   <= '0;
        end
        ST_DATA: if (w_hs) begin
          mem_addr_q  <= addr_q;
          mem_wdata_q <= bus.axi_wdata_i;
          mem_wstrb_q <= bus.axi_wstrb_i;
          last_q      <= bus.axi_wlast_i;
          addr_q      <= next_addr;
          // saturate so an overlong burst can't wrap back into the valid range
          if (cnt_q != '1) cnt_q <= cnt_q + {{AXI_LEN_W{1'b0}}, 1'b1};
          if (beat_err)    err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.axi_awready_o = awready_q;
  assign bus.axi_wready_o  = wready_q;
  assign bus.mem_valid_o   = mem_valid_q;
  assign bus.axi_bvalid_o  = bvalid_q;
  assign bus.axi_bid_o     = id_q;
  assign bus.axi_bresp_o   = (bvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_wdata_o   = mem_wdata_q;
  assign bus.mem_wstrb_o   = mem_wstrb_q;
endmodule

// File: tb/tb_iob_cache_axi_write_responder.sv
// Directed bench: table of write bursts with hand-computed memory writes and B responses, plus stall/reset sequences.
module tb_iob_cache_axi_write_responder;
  logic clk, reset_n;
  int   pass_cnt = 0, chk_cnt = 0;
  localparam int LIM = 60;

  iob_cache_axi_write_responder_if #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) bus ();

  iob_cache_axi_write_responder #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nb;
    int          nw;
    logic [1:0]  resp;
    logic [31:0] ea [4];
  } vec_t;

  vec_t vecs [9];

  logic [31:0] log_a [$];
  logic [31:0] log_d [$];
  logic [3:0]  log_s [$];

  always @(negedge clk)
    if (bus.mem_valid_o && bus.mem_ready_i) begin
      log_a.push_back(bus.mem_addr_o);
      log_d.push_back(bus.mem_wdata_o);
      log_s.push_back(bus.mem_wstrb_o);
    end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(input logic id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int nb,
                              input int nw, input logic [1:0] resp, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.nb = nb; v.nw = nw; v.resp = resp;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    return v;
  endfunction

  function automatic logic [31:0] wd(input int vi, input int b);
    if (vi == 0) return 32'hDEADBEEF;
    return 32'hA000_0000 | 32'(vi << 8) | 32'(b);
  endfunction

  function automatic logic [3:0] st(input int vi, input int b);
    if (vi == 0) return 4'hF;
    return 4'(b + 1);
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, "_hs"}, {bus.axi_awready_o, bus.axi_wready_o, bus.mem_valid_o, bus.axi_bvalid_o}, 4'b0000);
    chk({tag, "_b"}, {bus.axi_bresp_o, bus.axi_bid_o}, 3'b000);
    chk({tag, "_mem"}, {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o}, 68'h0);
  endtask

  task automatic do_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge clk);
    bus.axi_awid_i = id; bus.axi_awaddr_i = addr; bus.axi_awlen_i = len;
    bus.axi_awsize_i = size; bus.axi_awburst_i = burst; bus.axi_awvalid_i = 1'b1;
    while (!bus.axi_awready_o && n < LIM) begin @(negedge clk); n++; end
    chk("aw_wait", n >= LIM, 1'b0);
    @(posedge clk); #1 bus.axi_awvalid_i = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    int n = 0;
    @(negedge clk);
    bus.axi_wdata_i = d; bus.axi_wstrb_i = s; bus.axi_wlast_i = last; bus.axi_wvalid_i = 1'b1;
    while (!bus.axi_wready_o && n < LIM) begin @(negedge clk); n++; end
    chk("w_wait", n >= LIM, 1'b0);
    @(posedge clk); #1 bus.axi_wvalid_i = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] er, input logic eid, input int hold);
    int n = 0;
    @(negedge clk);
    while (!bus.axi_bvalid_o && n < LIM) begin @(negedge clk); n++; end
    chk("b_wait", n >= LIM, 1'b0);
    chk("bresp_bid", {bus.axi_bresp_o, bus.axi_bid_o}, {er, eid});
    for (int k = 0; k < hold; k++) begin
      chk("b_hold", {bus.axi_bvalid_o, bus.axi_bresp_o, bus.axi_bid_o, bus.axi_awready_o},
          {1'b1, er, eid, 1'b0});
      @(negedge clk);
    end
    bus.axi_bready_i = 1'b1;
    @(posedge clk); #1 bus.axi_bready_i = 1'b0;
    chk("aw_after_b", {bus.axi_awready_o, bus.axi_bvalid_o}, 2'b10);
  endtask

  task automatic clr_log();
    log_a.delete(); log_d.delete(); log_s.delete();
  endtask

  task automatic run_vec(input int vi, input int bhold);
    vec_t v = vecs[vi];
    clr_log();
    do_aw(v.id, v.addr, v.len, v.size, v.burst);
    for (int b = 0; b < v.nb; b++) do_w(wd(vi, b), st(vi, b), b == v.nb - 1);
    do_b(v.resp, v.id, bhold);
    chk($sformatf("v%0d_nwr", vi), log_a.size(), v.nw);
    for (int i = 0; i < v.nw && i < log_a.size(); i++)
      chk($sformatf("v%0d_wr%0d", vi, i), {log_a[i], log_d[i], log_s[i]}, {v.ea[i], wd(vi, i), st(vi, i)});
  endtask

  initial begin
    logic [31:0] ha, hd;
    logic [3:0]  hs;
    int          n;
    vecs[0] = mk(1'b1, 32'h40,       8'd0, 3'd2, 2'b01, 1, 1, 2'b00, 32'h40, 0, 0, 0);
    vecs[1] = mk(1'b0, 32'h100,      8'd3, 3'd2, 2'b01, 4, 4, 2'b00, 32'h100, 32'h104, 32'h108, 32'h10C);
    vecs[2] = mk(1'b1, 32'h20,       8'd2, 3'd2, 2'b00, 3, 3, 2'b00, 32'h20, 32'h20, 32'h20, 0);
    vecs[3] = mk(1'b0, 32'h200,      8'd3, 3'd2, 2'b10, 4, 0, 2'b10, 0, 0, 0, 0);
    vecs[4] = mk(1'b1, 32'h300,      8'd3, 3'd2, 2'b01, 2, 2, 2'b10, 32'h300, 32'h304, 0, 0);
    vecs[5] = mk(1'b0, 32'h0,        8'd0, 3'd3, 2'b01, 1, 0, 2'b10, 0, 0, 0, 0);
    vecs[6] = mk(1'b1, 32'h400,      8'd1, 3'd1, 2'b01, 3, 2, 2'b10, 32'h400, 32'h402, 0, 0);
    vecs[7] = mk(1'b0, 32'hFFFFFFFC, 8'd1, 3'd2, 2'b01, 2, 2, 2'b00, 32'hFFFFFFFC, 32'h0, 0, 0);
    vecs[8] = mk(1'b1, 32'h600,      8'd0, 3'd2, 2'b11, 1, 0, 2'b10, 0, 0, 0, 0);

    reset_n = 1'b0;
    bus.axi_awid_i = '0; bus.axi_awaddr_i = '0; bus.axi_awlen_i = '0; bus.axi_awsize_i = '0;
    bus.axi_awburst_i = '0; bus.axi_awvalid_i = 1'b0; bus.axi_wdata_i = '0; bus.axi_wstrb_i = '0;
    bus.axi_wlast_i = 1'b0; bus.axi_wvalid_i = 1'b0; bus.axi_bready_i = 1'b0; bus.mem_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("awready_post_rst", {bus.axi_awready_o, bus.axi_wready_o}, 2'b10);

    for (int i = 0; i < 9; i++) run_vec(i, 0);

    // B held under back-pressure
    run_vec(0, 5);

    // memory stall: payload must stay put while mem_ready_i is low
    clr_log();
    @(posedge clk); #1 bus.mem_ready_i = 1'b0;
    do_aw(1'b1, 32'h80, 8'd0, 3'd2, 2'b01);
    do_w(32'h1234_5678, 4'h3, 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.mem_valid_o && n < LIM) begin @(negedge clk); n++; end
    chk("stall_wait", n >= LIM, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ha = bus.mem_addr_o; hd = bus.mem_wdata_o; hs = bus.mem_wstrb_o;
      chk("stall_hold", {bus.mem_valid_o, ha, hd, hs}, {1'b1, 32'h80, 32'h1234_5678, 4'h3});
      @(negedge clk);
    end
    @(posedge clk); #1 bus.mem_ready_i = 1'b1;
    do_b(2'b00, 1'b1, 0);
    chk("stall_nwr", log_a.size(), 1);

    // reset during beat 2 of a 4-beat burst, then a fresh write
    do_aw(1'b1, 32'h500, 8'd3, 3'd2, 2'b01);
    do_w(wd(20, 0), 4'hF, 1'b0);
    do_w(wd(20, 1), 4'hF, 1'b0);
    reset_n = 1'b0;
    #1 chk_rst("mid_rst");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_noB", bus.axi_bvalid_o, 1'b0);
    run_vec(0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
